// File: rtl/comparador_serial_ctrl.sv
// -----------------------------------------------------------------------------
// comparador_serial_ctrl
//
// Serial magnitude comparator. The operands are captured on an accepted
// start. One (p,q) comparison cell then walks the captured operands one bit
// pair per clock, MSB first, starting from the "equal so far" state. The
// final (p,q) state is decoded into gt/lt/eq flags, and completion is
// signalled by a start/busy/done handshake.
//
// Parameters
//   N      operand width in bits (>= 2)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   abort  in   synchronous cancel, effective only in RUN
//   A, B   in   operands (N bits), captured on the accepting edge
//   busy   out  high while bits are being processed (RUN)
//   done   out  one-cycle completion pulse (DONE)
//   gt     out  A > B, held until the next accept, abort or reset
//   lt     out  A < B, same behaviour as gt
//   eq     out  A == B, same behaviour as gt
//   pq     out  live (p,q) cell state, for debug
//
// Build option
//   COMPARADOR_EARLY_EXIT_EN  When defined, the block finishes as soon as
//                             the cell reaches an absorbing state. The flag
//                             values are the same in both builds.
// -----------------------------------------------------------------------------
module comparador_serial_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         gt,
    output logic         lt,
    output logic         eq,
    output logic [1:0]   pq
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // (p,q) encodings
    localparam logic [1:0] PQ_EQ = 2'b01;
    localparam logic [1:0] PQ_GT = 2'b10;
    localparam logic [1:0] PQ_LT = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // One typical cell. 10 and 00 are absorbing. 11 is unreachable in normal
    // operation; if it ever appears, the cell falls back to the seed.
    function automatic logic [1:0] cell_next(input logic [1:0] pq_in,
                                             input logic       a_bit,
                                             input logic       b_bit);
        logic [1:0] r;
        case (pq_in)
            2'b01: begin
                if (a_bit && !b_bit) begin
                    r = PQ_GT;
                end else if (!a_bit && b_bit) begin
                    r = PQ_LT;
                end else begin
                    r = PQ_EQ;
                end
            end
            2'b10:   r = PQ_GT;
            2'b00:   r = PQ_LT;
            default: r = PQ_EQ;
        endcase
        return r;
    endfunction

    state_e         state_q, state_d;
    logic [N-1:0]   ar_q, ar_d;
    logic [N-1:0]   br_q, br_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     pq_q, pq_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           gt_q, gt_d;
    logic           lt_q, lt_d;
    logic           eq_q, eq_d;
    logic [1:0]     pq_nxt_s;
    logic           finish_s;

    // Next-state and registered-output computation for the controller
    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        pq_d     = pq_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        pq_nxt_s = cell_next(pq_q, ar_q[cnt_q], br_q[cnt_q]);
        finish_s = (cnt_q == {CW{1'b0}});
`ifdef COMPARADOR_EARLY_EXIT_EN
        if ((pq_nxt_s == PQ_GT) || (pq_nxt_s == PQ_LT)) begin
            finish_s = 1'b1;
        end else begin
            finish_s = (cnt_q == {CW{1'b0}});
        end
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    ar_d    = A;
                    br_d    = B;
                    pq_d    = PQ_EQ;
                    cnt_d   = CW'(N - 1);
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // abort takes priority, including over the final bit
                if (abort) begin
                    pq_d    = PQ_EQ;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (finish_s) begin
                    pq_d    = pq_nxt_s;
                    gt_d    = (pq_nxt_s == PQ_GT);
                    lt_d    = (pq_nxt_s == PQ_LT);
                    eq_d    = (pq_nxt_s == PQ_EQ);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    pq_d    = pq_nxt_s;
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                pq_d    = PQ_EQ;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state, shadow operands, bit counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ar_q    <= {N{1'b0}};
            br_q    <= {N{1'b0}};
            cnt_q   <= {CW{1'b0}};
            pq_q    <= PQ_EQ;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            pq_q    <= pq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign pq   = pq_q;

endmodule
